// File: rtl/hps_frame_window_reader.sv
// Avalon-MM slave that captures a programmable window of one camera frame into a FIFO for HPS reads.
// Optional macro HPS_PIX_XFER_IRQ_EN enables the level interrupt on done/sync_err.
`timescale 1ns/1ps
module hps_frame_window_reader #(
    parameter int unsigned PIX_W      = 24,
    parameter int unsigned FRAME_W    = 640,
    parameter int unsigned FRAME_H    = 480,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned CW         = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_data,
    input  logic [2:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             waitrequest,
    output logic             irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    x_q, x_d, y_q, y_d;
    logic [CW-1:0]    win_x0_q, win_x0_d, win_x1_q, win_x1_d;
    logic [CW-1:0]    win_y0_q, win_y0_d, win_y1_q, win_y1_d;
    logic             done_q, done_d, ovf_q, ovf_d, sync_q, sync_d;
    logic [31:0]      count_q, count_d;
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             rd_ack_q, rd_ack_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [PIX_W-1:0] mem_q [FIFO_DEPTH];

    logic          rd_load, wr_ctrl, ctl_start, ctl_abort, ctl_clr, start_go;
    logic [LW-1:0] level;
    logic          fifo_empty, fifo_full, pop, push, want_push, ovf_set;
    logic [CW-1:0] cur_x, cur_y;
    logic          in_win, at_end, win_empty, busy;
    logic          eval, done_set, sync_set;
    logic [31:0]   rd_mux;
    logic          unused_wdata;

    assign unused_wdata = ^writedata;

    // Bus decode: a read stalls exactly one cycle, the load edge is the first one.
    always_comb begin
        rd_load    = read & ~rd_ack_q;
        wr_ctrl    = write & (address == 3'd1);
        ctl_start  = wr_ctrl & writedata[0];
        ctl_abort  = wr_ctrl & writedata[1];
        ctl_clr    = wr_ctrl & writedata[2];
        level      = wr_ptr_q - rd_ptr_q;
        fifo_empty = (level == '0);
        fifo_full  = (level == LW'(FIFO_DEPTH));
        pop        = rd_load & (address == 3'd2) & ~fifo_empty;
        busy       = (state_q != ST_IDLE);
    end

    assign waitrequest = rd_load;

    // Coordinates of the pixel presented this cycle; sof forces the origin.
    always_comb begin
        cur_x     = pix_sof ? '0 : x_q;
        cur_y     = pix_sof ? '0 : y_q;
        in_win    = (cur_x >= win_x0_q) && (cur_x <= win_x1_q) &&
                    (cur_y >= win_y0_q) && (cur_y <= win_y1_q);
        at_end    = (cur_x == win_x1_q) && (cur_y == win_y1_q);
        win_empty = (win_x1_q < win_x0_q) || (win_y1_q < win_y0_q);
        x_d = x_q;
        y_d = y_q;
        if (pix_valid) begin
            if (cur_x == CW'(FRAME_W - 1)) begin
                x_d = '0;
                y_d = (cur_y == CW'(FRAME_H - 1)) ? cur_y : cur_y + CW'(1);
            end else begin
                x_d = cur_x + CW'(1);
                y_d = cur_y;
            end
        end
    end

    // Capture sequencing; abort overrides every pixel and start event.
    always_comb begin
        state_d  = state_q;
        eval     = 1'b0;
        done_set = 1'b0;
        sync_set = 1'b0;
        start_go = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctl_start && !ctl_abort) begin
                    start_go = 1'b1;
                    if (win_empty) begin
                        done_set = 1'b1;
                    end else begin
                        state_d = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (pix_valid && pix_sof) begin
                    state_d = ST_CAPTURE;
                    eval    = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (pix_valid) begin
                    if (pix_sof) begin
                        sync_set = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        eval = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (eval && at_end) begin
            done_set = 1'b1;
            state_d  = ST_IDLE;
        end
        if (ctl_abort) begin
            state_d  = ST_IDLE;
            eval     = 1'b0;
            done_set = 1'b0;
            sync_set = 1'b0;
        end
    end

    // FIFO, flags and counters.
    always_comb begin
        want_push = eval & in_win;
        push      = want_push & (~fifo_full | pop);
        ovf_set   = want_push & fifo_full & ~pop;

        wr_ptr_d = wr_ptr_q + LW'(push);
        rd_ptr_d = rd_ptr_q + LW'(pop);
        if (ctl_abort) begin
            rd_ptr_d = wr_ptr_q;
        end

        done_d = done_q;
        ovf_d  = ovf_q;
        sync_d = sync_q;
        if (ctl_clr || start_go) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
            sync_d = 1'b0;
        end
        if (done_set) done_d = 1'b1;
        if (ovf_set)  ovf_d  = 1'b1;
        if (sync_set) sync_d = 1'b1;

        count_d = count_q;
        if (start_go) begin
            count_d = '0;
        end else if (push) begin
            count_d = count_q + 32'd1;
        end

        win_x0_d = win_x0_q;
        win_x1_d = win_x1_q;
        win_y0_d = win_y0_q;
        win_y1_d = win_y1_q;
        if (write && (address == 3'd3)) begin
            win_x0_d = writedata[CW-1:0];
            win_x1_d = writedata[16 +: CW];
        end
        if (write && (address == 3'd4)) begin
            win_y0_d = writedata[CW-1:0];
            win_y1_d = writedata[16 +: CW];
        end
    end

    // Read data mux, captured on the load edge only.
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0: rd_mux = {16'(level), 12'd0, sync_q, ovf_q, done_q, busy};
            3'd2: begin
                if (!fifo_empty) begin
                    rd_mux     = 32'(mem_q[rd_ptr_q[AW-1:0]]);
                    rd_mux[31] = 1'b1;
                end
            end
            3'd3: rd_mux = (32'(win_x1_q) << 16) | 32'(win_x0_q);
            3'd4: rd_mux = (32'(win_y1_q) << 16) | 32'(win_y0_q);
            3'd5: rd_mux = count_q;
            default: rd_mux = '0;
        endcase
        readdata_d = rd_load ? rd_mux : readdata_q;
        rd_ack_d   = rd_load;
    end

    assign readdata = readdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            win_x0_q   <= '0;
            win_x1_q   <= CW'(FRAME_W - 1);
            win_y0_q   <= '0;
            win_y1_q   <= CW'(FRAME_H - 1);
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            sync_q     <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_ack_q   <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            win_x0_q   <= win_x0_d;
            win_x1_q   <= win_x1_d;
            win_y0_q   <= win_y0_d;
            win_y1_q   <= win_y1_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            sync_q     <= sync_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_ack_q   <= rd_ack_d;
            readdata_q <= readdata_d;
        end
    end

    // Pixel storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= pix_data;
        end
    end

`ifdef HPS_PIX_XFER_IRQ_EN
    logic done_p_q, sync_p_q, irq_q, irq_d;

    // Interrupt follows the registered rise of done or sync_err, held until clear.
    always_comb begin
        irq_d = irq_q;
        if (ctl_clr) irq_d = 1'b0;
        if ((done_q & ~done_p_q) | (sync_q & ~sync_p_q)) irq_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_p_q <= 1'b0;
            sync_p_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            done_p_q <= done_q;
            sync_p_q <= sync_q;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_hps_frame_window_reader.sv
// Scoreboard bench for hps_frame_window_reader with a frame-index reference model.
`timescale 1ns/1ps
module tb_hps_frame_window_reader;
    localparam int unsigned PIX_W = 24;
    localparam int unsigned FW    = 8;
    localparam int unsigned FH    = 4;
    localparam int unsigned D     = 4;
    localparam int unsigned CW    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pix_valid = 1'b0, pix_sof = 1'b0;
    logic [PIX_W-1:0] pix_data = '0;
    logic [2:0]       address = '0;
    logic             read = 1'b0, write = 1'b0;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic             waitrequest, irq;

    hps_frame_window_reader #(
        .PIX_W(PIX_W), .FRAME_W(FW), .FRAME_H(FH), .FIFO_DEPTH(D), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_data(pix_data), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               sof;
        logic [PIX_W-1:0] data;
    } pix_t;

    int          total = 0, bad = 0;
    pix_t        pend[$];
    logic [31:0] expq[$];
    int          expa[$];
    int          pix_rate = 100;
    bit          force_pix = 0;

    logic [PIX_W-1:0] mq[$];
    int mode, m_count, m_idx, wx0, wx1, wy0, wy1;
    bit m_done, m_ovf, m_sync, m_irq;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mode = 0; m_count = 0; m_idx = 0;
        wx0 = 0; wx1 = FW - 1; wy0 = 0; wy1 = FH - 1;
        m_done = 0; m_ovf = 0; m_sync = 0; m_irq = 0;
    endtask

    // Reference behaviour for one clock edge, from the current bus/stream inputs.
    task automatic model_edge(input bit load);
        bit pop, od, os, eval, st, ab, cl;
        int x, y, pre_mode;
        logic [31:0] rd;
        pop = 0; od = m_done; os = m_sync; eval = 0; pre_mode = mode; x = 0; y = 0;
        st = write && address == 3'd1 && writedata[0];
        ab = write && address == 3'd1 && writedata[1];
        cl = write && address == 3'd1 && writedata[2];
        if (load) begin
            rd = 32'h0;
            case (address)
                3'd0: rd = {16'(mq.size()), 12'd0, m_sync, m_ovf, m_done, mode != 0};
                3'd2: if (mq.size() > 0) begin rd = 32'h8000_0000 | 32'(mq[0]); pop = 1; end
                3'd3: rd = (32'(wx1) << 16) | 32'(wx0);
                3'd4: rd = (32'(wy1) << 16) | 32'(wy0);
                3'd5: rd = 32'(m_count);
                default: rd = 32'h0;
            endcase
            expq.push_back(rd);
            expa.push_back(int'(address));
        end
        if (cl) begin m_done = 0; m_ovf = 0; m_sync = 0; m_irq = 0; end
        if (pix_valid) begin
            if (pix_sof) m_idx = 0;
            x = m_idx % FW;
            y = m_idx / FW;
            if (y > FH - 1) y = FH - 1;
            m_idx++;
        end
        if (ab) begin
            mode = 0;
            mq.delete();
        end else begin
            if (pop) mq.delete(0);
            if (pix_valid) begin
                if (mode == 1 && pix_sof) begin mode = 2; eval = 1; end
                else if (mode == 2) begin
                    if (pix_sof) begin m_sync = 1; mode = 0; end
                    else eval = 1;
                end
                if (eval) begin
                    if (x >= wx0 && x <= wx1 && y >= wy0 && y <= wy1) begin
                        if (mq.size() < D) begin mq.push_back(pix_data); m_count++; end
                        else m_ovf = 1;
                    end
                    if (x == wx1 && y == wy1) begin m_done = 1; mode = 0; end
                end
            end
            if (st && pre_mode == 0) begin
                m_count = 0; m_done = 0; m_ovf = 0; m_sync = 0;
                if (wx1 < wx0 || wy1 < wy0) m_done = 1;
                else mode = 1;
            end
        end
        if (write && address == 3'd3) begin wx0 = int'(writedata[CW-1:0]); wx1 = int'(writedata[16 +: CW]); end
        if (write && address == 3'd4) begin wy0 = int'(writedata[CW-1:0]); wy1 = int'(writedata[16 +: CW]); end
        if ((m_done && !od) || (m_sync && !os)) m_irq = 1;
    endtask

    task automatic tick(input bit load);
        if (pend.size() > 0 && (force_pix || $urandom_range(99) < pix_rate)) begin
            pix_valid = 1'b1; pix_sof = pend[0].sof; pix_data = pend[0].data;
            pend.delete(0);
        end else begin
            pix_valid = 1'b0; pix_sof = 1'($urandom_range(1)); pix_data = PIX_W'($urandom);
        end
        @(posedge clk);
        model_edge(load);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick(0);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input bit fp);
        address = a; read = 1'b1;
        @(negedge clk);
        chk("waitrequest first cycle", 32'(waitrequest), 32'd1);
        force_pix = fp;
        tick(1);
        force_pix = 0;
        tick(0);
        read = 1'b0;
    endtask

    task automatic add_frame(input int n, input int sof_at, input bit idx_data);
        for (int i = 0; i < n; i++) begin
            pix_t p;
            p.sof  = (i == 0) || (i == sof_at);
            p.data = idx_data ? PIX_W'(i) : PIX_W'($urandom);
            pend.push_back(p);
        end
    endtask

    task automatic rd_all();
        for (int a = 0; a < 8; a++) bus_read(3'(a), 0);
    endtask

    task automatic chk_irq(input string name);
`ifdef HPS_PIX_XFER_IRQ_EN
        chk(name, 32'(irq), 32'(m_irq));
`else
        chk(name, 32'(irq), 32'd0);
`endif
    endtask

    // Monitor: every acknowledged read is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && read === 1'b1 && waitrequest === 1'b0) begin
            if (expq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected read ack got=%h expected=none", readdata);
            end else begin
                chk($sformatf("read addr%0d", expa[0]), readdata, expq[0]);
                expq.delete(0);
                expa.delete(0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #1;
        chk("reset readdata", readdata, 32'h0);
        chk("reset waitrequest", 32'(waitrequest), 32'h0);
        chk("reset irq", 32'(irq), 32'h0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        rd_all();

        // Full window, data = index, reader keeps up with the stream.
        pix_rate = 20;
        bus_write(3'd1, 32'h1);
        add_frame(FW * FH, -1, 1);
        while (pend.size() > 0) bus_read(3'd2, 0);
        repeat (6) bus_read(3'd2, 0);
        bus_read(3'd0, 0); bus_read(3'd5, 0);
        repeat (2) tick(0);
        chk_irq("irq after done");
        bus_write(3'd1, 32'h4);
        repeat (2) tick(0);
        chk_irq("irq after clear");

        // Sub-window x 2..5, y 1..2.
        bus_write(3'd3, 32'h0005_0002);
        bus_write(3'd4, 32'h0002_0001);
        bus_write(3'd1, 32'h1);
        add_frame(FW * FH, -1, 1);
        while (pend.size() > 0) bus_read(3'd2, 0);
        repeat (6) bus_read(3'd2, 0);
        bus_read(3'd5, 0);

        // Full window, no reads: FIFO fills and overflows.
        pix_rate = 100;
        bus_write(3'd3, 32'h0007_0000);
        bus_write(3'd4, 32'h0003_0000);
        bus_write(3'd1, 32'h1);
        add_frame(FW * FH, -1, 0);
        while (pend.size() > 0) tick(0);
        bus_read(3'd0, 0); bus_read(3'd5, 0);
        repeat (5) bus_read(3'd2, 0);

        // Second sof at pixel 5 -> sync error.
        bus_write(3'd1, 32'h4);
        bus_write(3'd3, 32'h0007_0002);
        bus_write(3'd1, 32'h1);
        add_frame(12, 5, 0);
        while (pend.size() > 0) tick(0);
        repeat (2) tick(0);
        bus_read(3'd0, 0);
        chk_irq("irq after sync_err");
        repeat (5) bus_read(3'd2, 0);

        // Abort mid-frame, abort+start together, empty window.
        bus_write(3'd1, 32'h4);
        bus_write(3'd3, 32'h0007_0000);
        bus_write(3'd1, 32'h1);
        add_frame(FW * FH, -1, 0);
        repeat (12) tick(0);
        bus_write(3'd1, 32'h2);
        bus_read(3'd0, 0);
        while (pend.size() > 0) tick(0);
        bus_write(3'd1, 32'h3);
        bus_read(3'd0, 0);
        bus_write(3'd3, 32'h0001_0005);
        bus_write(3'd1, 32'h1);
        bus_read(3'd0, 0);
        repeat (2) tick(0);
        chk_irq("irq after empty window");

        // Full FIFO with a pixel landing on the same edge as a DATA pop.
        bus_write(3'd1, 32'h6);
        bus_write(3'd3, 32'h0004_0000);
        bus_write(3'd4, 32'h0000_0000);
        bus_write(3'd1, 32'h1);
        add_frame(4, -1, 0);
        while (pend.size() > 0) tick(0);
        bus_read(3'd0, 0);
        pix_rate = 0;
        add_frame(1, -1, 0);
        pend[0].sof = 0;
        bus_read(3'd2, 1);
        bus_read(3'd0, 0);
        repeat (5) bus_read(3'd2, 0);

        // Randomized windows, rates, stray sofs and bus traffic.
        repeat (30) begin
            int x0, x1, y0, y1;
            x0 = $urandom_range(FW - 1); x1 = $urandom_range(FW - 1);
            y0 = $urandom_range(FH - 1); y1 = $urandom_range(FH - 1);
            if ($urandom_range(3) != 0 && x1 < x0) begin int t; t = x0; x0 = x1; x1 = t; end
            if ($urandom_range(3) != 0 && y1 < y0) begin int t; t = y0; y0 = y1; y1 = t; end
            pix_rate = $urandom_range(10, 100);
            bus_write(3'd3, (32'(x1) << 16) | 32'(x0));
            bus_write(3'd4, (32'(y1) << 16) | 32'(y0));
            if ($urandom_range(2) == 0) bus_write(3'd1, 32'h4);
            bus_write(3'd1, 32'h1);
            add_frame(FW * FH + $urandom_range(4), ($urandom_range(3) == 0) ? $urandom_range(1, 31) : -1, 0);
            while (pend.size() > 0) begin
                case ($urandom_range(7))
                    0: bus_read(3'd0, 0);
                    1, 2, 3: bus_read(3'd2, 0);
                    4: bus_read(3'($urandom_range(7)), 0);
                    5: tick(0);
                    6: if ($urandom_range(9) == 0) bus_write(3'd1, 32'h2); else tick(0);
                    default: if ($urandom_range(5) == 0)
                                 bus_write(3'd3, (32'($urandom_range(FW - 1)) << 16)); else tick(0);
                endcase
            end
            repeat (2) tick(0);
            bus_read(3'd0, 0); bus_read(3'd5, 0);
            repeat (3) bus_read(3'd2, 0);
            chk_irq("irq random");
        end

        // Asynchronous reset in the middle of a capture.
        pix_rate = 100;
        bus_write(3'd3, 32'h0007_0000);
        bus_write(3'd4, 32'h0003_0000);
        bus_write(3'd1, 32'h5);
        add_frame(FW * FH, -1, 0);
        repeat (10) tick(0);
        bus_read(3'd2, 0);
        #2 rst_n = 1'b0;
        pix_valid = 1'b0;
        #1;
        chk("midreset readdata", readdata, 32'h0);
        chk("midreset waitrequest", 32'(waitrequest), 32'h0);
        chk("midreset irq", 32'(irq), 32'h0);
        pend.delete();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_all();
        pix_rate = 30;
        bus_write(3'd1, 32'h1);
        add_frame(FW * FH, -1, 0);
        while (pend.size() > 0) bus_read(3'd2, 0);
        repeat (5) bus_read(3'd2, 0);
        bus_read(3'd0, 0); bus_read(3'd5, 0);

        repeat (3) tick(0);
        chk("scoreboard drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
